// File: rtl/mips_pkg.sv
// Shared encodings and default widths for the pipelined MIPS core.
package mips_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned RADDR = 5;

   // Load size encodings; 2'b11 is treated as a word.
   localparam logic [1:0] LS_WORD = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_BYTE = 2'b10;

   localparam logic [RADDR-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction and sign/zero extension.
// Ports:
//   size      load size (LS_WORD / LS_HALF / LS_BYTE, 11 = word)
//   is_signed sign-extend (1) or zero-extend (0)
//   off       address bits [1:0]; a half uses off[1] only, a word ignores off
//   data      raw aligned memory word
//   result    extracted and extended load value
module load_align
   import mips_pkg::*;
#(
   parameter int unsigned XLEN_P = XLEN
) (
   input  logic [1:0]        size,
   input  logic              is_signed,
   input  logic [1:0]        off,
   input  logic [XLEN_P-1:0] data,
   output logic [XLEN_P-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection from the address offset.
   always_comb begin
      byte_sel = data[7:0];
      case (off)
         2'd0:    byte_sel = data[7:0];
         2'd1:    byte_sel = data[15:8];
         2'd2:    byte_sel = data[23:16];
         default: byte_sel = data[31:24];
      endcase
      half_sel = off[1] ? data[31:16] : data[15:0];
   end

   // Extension to the full datapath width.
   always_comb begin
      result = data;
      case (size)
         LS_HALF: result = {{(XLEN_P-16){is_signed & half_sel[15]}}, half_sel};
         LS_BYTE: result = {{(XLEN_P-8){is_signed & byte_sel[7]}}, byte_sel};
         default: result = data;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback logic; sole driver of the regfile
// write port. Also presents decode operands.
// Build option: WB_BYPASS_EN forwards the in-flight regfile write to the
// decode operands; without it the raw regfile read data is passed through.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready, stall, flush capture handshake and hazard control
//   in_*                            retiring instruction fields from MEM
//   rf_write/rf_addr/rf_data        regfile write port (zero when idle)
//   rd_addr_a/_b, rf_data_a/_b      decode read addresses and raw read data
//   op_a/op_b                       decode operands
//   retired                         count of retired instructions
module writeback_stage
   import mips_pkg::*;
#(
   parameter int unsigned XLEN_P  = XLEN,
   parameter int unsigned RADDR_P = RADDR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               stall,
   input  logic               flush,
   input  logic               in_reg_write,
   input  logic               in_mem_to_reg,
   input  logic [1:0]         in_load_size,
   input  logic               in_load_signed,
   input  logic [1:0]         in_byte_off,
   input  logic [XLEN_P-1:0]  in_alu_result,
   input  logic [XLEN_P-1:0]  in_mem_data,
   input  logic [RADDR_P-1:0] in_dest,
   output logic               rf_write,
   output logic [RADDR_P-1:0] rf_addr,
   output logic [XLEN_P-1:0]  rf_data,
   input  logic [RADDR_P-1:0] rd_addr_a,
   input  logic [RADDR_P-1:0] rd_addr_b,
   input  logic [XLEN_P-1:0]  rf_data_a,
   input  logic [XLEN_P-1:0]  rf_data_b,
   output logic [XLEN_P-1:0]  op_a,
   output logic [XLEN_P-1:0]  op_b,
   output logic [31:0]        retired
);

   logic               wb_valid;
   logic               wb_done;
   logic               wb_reg_write;
   logic               wb_mem_to_reg;
   logic [1:0]         wb_load_size;
   logic               wb_load_signed;
   logic [1:0]         wb_byte_off;
   logic [XLEN_P-1:0]  wb_alu_result;
   logic [XLEN_P-1:0]  wb_mem_data;
   logic [RADDR_P-1:0] wb_dest;

   logic               commit;
   logic [XLEN_P-1:0]  load_value;
   logic [XLEN_P-1:0]  result;

   assign in_ready = !stall;

   // First cycle of a valid entry; a reset in that cycle drops it unwritten.
   assign commit = wb_valid & !wb_done & !reset;

   // WB register: flush beats capture, stall holds and marks the entry done.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid       <= 1'b0;
         wb_done        <= 1'b0;
         wb_reg_write   <= 1'b0;
         wb_mem_to_reg  <= 1'b0;
         wb_load_size   <= LS_WORD;
         wb_load_signed <= 1'b0;
         wb_byte_off    <= 2'd0;
         wb_alu_result  <= '0;
         wb_mem_data    <= '0;
         wb_dest        <= '0;
      end else if (flush) begin
         wb_valid <= 1'b0;
         wb_done  <= 1'b0;
      end else if (stall) begin
         if (wb_valid) wb_done <= 1'b1;
      end else if (in_valid) begin
         wb_valid       <= 1'b1;
         wb_done        <= 1'b0;
         wb_reg_write   <= in_reg_write;
         wb_mem_to_reg  <= in_mem_to_reg;
         wb_load_size   <= in_load_size;
         wb_load_signed <= in_load_signed;
         wb_byte_off    <= in_byte_off;
         wb_alu_result  <= in_alu_result;
         wb_mem_data    <= in_mem_data;
         wb_dest        <= in_dest;
      end else begin
         wb_valid <= 1'b0;
         wb_done  <= 1'b0;
      end
   end

   // Retirement counter, once per entry whether or not it writes.
   always_ff @(posedge clk) begin
      if (reset)       retired <= 32'd0;
      else if (commit) retired <= retired + 32'd1;
   end

   load_align #(.XLEN_P(XLEN_P)) u_load_align (
      .size      (wb_load_size),
      .is_signed (wb_load_signed),
      .off       (wb_byte_off),
      .data      (wb_mem_data),
      .result    (load_value)
   );

   assign result = wb_mem_to_reg ? load_value : wb_alu_result;

   // Regfile write port, held at zero when not writing.
   always_comb begin
      rf_write = commit & wb_reg_write & (wb_dest != RADDR_P'(REG_ZERO));
      rf_addr  = '0;
      rf_data  = '0;
      if (rf_write) begin
         rf_addr = wb_dest;
         rf_data = result;
      end
   end

   // Decode operands.
   always_comb begin
      op_a = rf_data_a;
      op_b = rf_data_b;
`ifdef WB_BYPASS_EN
      if (rf_write && rd_addr_a == rf_addr && rd_addr_a != RADDR_P'(REG_ZERO)) op_a = rf_data;
      if (rf_write && rd_addr_b == rf_addr && rd_addr_b != RADDR_P'(REG_ZERO)) op_b = rf_data;
`else
      if (rd_addr_a == rd_addr_b) begin
         op_a = rf_data_a;
      end
`endif
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases plus randomized
// traffic against a behavioural model of the retiring entry.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, stall, flush;
   logic        in_reg_write, in_mem_to_reg, in_load_signed;
   logic [1:0]  in_load_size, in_byte_off;
   logic [31:0] in_alu_result, in_mem_data;
   logic [4:0]  in_dest;
   logic        rf_write;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [4:0]  rd_addr_a, rd_addr_b;
   logic [31:0] rf_data_a, rf_data_b, op_a, op_b, retired;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   writeback_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .stall(stall), .flush(flush), .in_reg_write(in_reg_write),
      .in_mem_to_reg(in_mem_to_reg), .in_load_size(in_load_size),
      .in_load_signed(in_load_signed), .in_byte_off(in_byte_off),
      .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_dest(in_dest),
      .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
      .op_a(op_a), .op_b(op_b), .retired(retired)
   );

   // Model: the entry currently in WB and whether it has been committed.
   typedef struct {
      bit          rw;
      bit          mtr;
      bit [1:0]    size;
      bit          sgn;
      bit [1:0]    off;
      bit [31:0]   alu;
      bit [31:0]   mem;
      bit [4:0]    dest;
   } entry_t;

   entry_t      m_entry;
   bit          m_valid;
   bit          m_committed;
   bit [31:0]   m_retired;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit [31:0] model_load(input entry_t e);
      bit [31:0] v;
      case (e.size)
         2'b01: begin
            v = (e.mem >> (16 * int'(e.off[1]))) & 32'h0000_FFFF;
            if (e.sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
         end
         2'b10: begin
            v = (e.mem >> (8 * int'(e.off))) & 32'h0000_00FF;
            if (e.sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
         end
         default: v = e.mem;
      endcase
      return v;
   endfunction

   // Check every output for the current cycle, then advance the model across the coming edge.
   task automatic tick();
      bit        exp_wr;
      bit [31:0] exp_data, exp_a, exp_b;
      #1;
      exp_wr   = !reset && m_valid && !m_committed && m_entry.rw && m_entry.dest != 5'd0;
      exp_data = m_entry.mtr ? model_load(m_entry) : m_entry.alu;
      exp_a    = rf_data_a;
      exp_b    = rf_data_b;
`ifdef WB_BYPASS_EN
      if (exp_wr && rd_addr_a == m_entry.dest) exp_a = exp_data;
      if (exp_wr && rd_addr_b == m_entry.dest) exp_b = exp_data;
`endif
      check("in_ready", 32'(in_ready), 32'(!stall));
      check("rf_write", 32'(rf_write), 32'(exp_wr));
      check("rf_addr",  32'(rf_addr),  exp_wr ? 32'(m_entry.dest) : 32'd0);
      check("rf_data",  rf_data,       exp_wr ? exp_data : 32'd0);
      check("op_a",     op_a,          exp_a);
      check("op_b",     op_b,          exp_b);
      check("retired",  retired,       m_retired);

      if (reset) begin
         m_valid = 0; m_committed = 0; m_retired = 0;
      end else begin
         if (m_valid && !m_committed) m_retired = m_retired + 32'd1;
         if (flush) m_valid = 0;
         else if (stall) begin
            if (m_valid) m_committed = 1;
         end else if (in_valid) begin
            m_valid = 1; m_committed = 0;
            m_entry.rw = in_reg_write;   m_entry.mtr = in_mem_to_reg;
            m_entry.size = in_load_size; m_entry.sgn = in_load_signed;
            m_entry.off = in_byte_off;   m_entry.alu = in_alu_result;
            m_entry.mem = in_mem_data;   m_entry.dest = in_dest;
         end else m_valid = 0;
      end
      @(negedge clk);
   endtask

   task automatic load_case(input string tag, input logic [1:0] size, input logic sgn,
                            input logic [1:0] off, input logic [31:0] exp);
      in_valid = 1; in_reg_write = 1; in_mem_to_reg = 1; in_dest = 5'd3;
      in_mem_data = 32'h80FF_7F01; in_load_size = size; in_load_signed = sgn;
      in_byte_off = off; in_alu_result = 32'hDEAD_BEEF;
      tick();
      in_valid = 0;
      #1;
      check(tag, rf_data, exp);
      tick();
   endtask

   initial begin
      bit [31:0] r0;
      reset = 1; in_valid = 0; stall = 0; flush = 0;
      in_reg_write = 0; in_mem_to_reg = 0; in_load_size = 2'b00; in_load_signed = 0;
      in_byte_off = 0; in_alu_result = 0; in_mem_data = 0; in_dest = 0;
      rd_addr_a = 0; rd_addr_b = 0; rf_data_a = 32'h1111_1111; rf_data_b = 32'h2222_2222;
      m_valid = 0; m_committed = 0; m_retired = 0;
      m_entry = '{default: 0};
      @(negedge clk);
      tick(); tick();
      reset = 0;
      #1;
      check("reset_retired", retired, 32'd0);
      check("reset_rf_write", 32'(rf_write), 32'd0);
      tick();

      // ALU write to r8
      in_valid = 1; in_reg_write = 1; in_mem_to_reg = 0; in_alu_result = 32'h0000_1234; in_dest = 5'd8;
      tick();
      in_valid = 0;
      #1;
      check("alu_wr", 32'(rf_write), 32'd1);
      check("alu_addr", 32'(rf_addr), 32'd8);
      check("alu_data", rf_data, 32'h0000_1234);
      tick();
      check("alu_retired", retired, 32'd1);

      // Load alignment corners
      load_case("ld_byte_s3", 2'b10, 1'b1, 2'd3, 32'hFFFF_FF80);
      load_case("ld_byte_u2", 2'b10, 1'b0, 2'd2, 32'h0000_00FF);
      load_case("ld_half_s2", 2'b01, 1'b1, 2'd2, 32'hFFFF_80FF);
      load_case("ld_half_s1", 2'b01, 1'b1, 2'd1, 32'h0000_7F01);
      load_case("ld_word_11", 2'b11, 1'b1, 2'd3, 32'h80FF_7F01);

      // Write to r0 is suppressed but still retires
      r0 = retired;
      in_valid = 1; in_reg_write = 1; in_mem_to_reg = 0; in_dest = 5'd0;
      tick();
      in_valid = 0;
      #1;
      check("r0_no_write", 32'(rf_write), 32'd0);
      tick();
      check("r0_retired", retired, r0 + 32'd1);

      // Stall held three cycles: one write, one retirement
      r0 = retired;
      in_valid = 1; in_dest = 5'd9; in_alu_result = 32'h0000_0099;
      tick();
      in_valid = 0; stall = 1;
      #1;
      check("stall_wr_first", 32'(rf_write), 32'd1);
      check("stall_ready", 32'(in_ready), 32'd0);
      tick();
      check("stall_wr_again", 32'(rf_write), 32'd0);
      tick(); tick();
      stall = 0;
      check("stall_retired", retired, r0 + 32'd1);
      tick();

      // Flush beats capture
      in_valid = 1; flush = 1; in_dest = 5'd10;
      tick();
      in_valid = 0; flush = 0;
      #1;
      check("flush_no_write", 32'(rf_write), 32'd0);
      tick();

      // Reset with an entry pending
      in_valid = 1; in_dest = 5'd11;
      tick();
      in_valid = 0; reset = 1;
      #1;
      check("rst_pend_no_write", 32'(rf_write), 32'd0);
      tick();
      reset = 0;
      check("rst_pend_retired", retired, 32'd0);
      tick();

      // Bypass on a write to r5
      in_valid = 1; in_dest = 5'd5; in_alu_result = 32'h5555_0005;
      tick();
      in_valid = 0; rd_addr_a = 5'd5; rd_addr_b = 5'd0;
      rf_data_a = 32'hAAAA_AAAA; rf_data_b = 32'hBBBB_BBBB;
      #1;
`ifdef WB_BYPASS_EN
      check("bypass_op_a", op_a, 32'h5555_0005);
`else
      check("bypass_op_a", op_a, 32'hAAAA_AAAA);
`endif
      check("bypass_op_b_r0", op_b, 32'hBBBB_BBBB);
      tick();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 199) == 0);
         in_valid       = ($urandom_range(0, 9) < 7);
         stall          = ($urandom_range(0, 9) < 2);
         flush          = ($urandom_range(0, 19) == 0);
         in_reg_write   = ($urandom_range(0, 9) < 8);
         in_mem_to_reg  = $urandom_range(0, 1);
         in_load_size   = 2'($urandom_range(0, 3));
         in_load_signed = $urandom_range(0, 1);
         in_byte_off    = 2'($urandom_range(0, 3));
         in_alu_result  = $urandom;
         in_mem_data    = $urandom;
         in_dest        = 5'($urandom_range(0, 7));
         rd_addr_a      = 5'($urandom_range(0, 7));
         rd_addr_b      = 5'($urandom_range(0, 7));
         rf_data_a      = $urandom;
         rf_data_b      = $urandom;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
